// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N input channels plus the single
// registered output stream. The mux connects through the slave modport.
// The producer/consumer side connects through the master modport.
interface stream_mux_rr_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_sel;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_last, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_last, out_sel, out_valid
    );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel round-robin stream multiplexer with a single
// registered output stage (1-cycle latency, full throughput).
// Optional feature macro: STREAM_MUX_LAST_EN enables packet-atomic arbitration.
// With the macro, a channel keeps the grant from its first beat until its
// in_last beat, and the pointer advances only on last beats. Without it,
// every beat is arbitrated independently and out_last is tied to 0.
module stream_mux_rr #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input logic            clk,
    input logic            rst,
    stream_mux_rr_if.slave bus
);

    // Output register stage and arbitration state.
    logic [W-1:0]  data_p1;
    logic          last_p1;
    logic [SW-1:0] sel_p1;
    logic          vld_p1;
    logic [SW-1:0] ptr;

`ifdef STREAM_MUX_LAST_EN
    logic          lock;
    logic [SW-1:0] lock_ch;
`endif

    // Combinational arbitration signals.
    logic          load;
    logic          found;
    logic [SW-1:0] gidx;
    logic [N-1:0]  grant;
    logic          xfer;
    logic [W-1:0]  data_sel;
    logic          last_sel;
    int            scan_pos;
    logic [SW-1:0] scan_idx;

    // Next round-robin position after channel g, wrapping at N-1.
    function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] g);
        if (int'(g) == N - 1)
            return '0;
        else
            return g + SW'(1);
    endfunction

    assign load = !vld_p1 | bus.out_ready;
    assign xfer = load & found;

    // Pick the first valid channel scanning upward from ptr (or the locked channel).
    always_comb begin
        found    = 1'b0;
        gidx     = '0;
        grant    = '0;
        scan_pos = 0;
        scan_idx = '0;
`ifdef STREAM_MUX_LAST_EN
        if (lock) begin
            gidx  = lock_ch;
            found = bus.in_valid[lock_ch];
        end else begin
`else
        begin
`endif
            for (int k = 0; k < N; k++) begin
                scan_pos = int'(ptr) + k;
                if (scan_pos >= N)
                    scan_pos = scan_pos - N;
                scan_idx = SW'(scan_pos);
                if (!found && bus.in_valid[scan_idx]) begin
                    found = 1'b1;
                    gidx  = scan_idx;
                end
            end
        end
        if (found)
            grant[gidx] = 1'b1;
    end

    // Select the granted channel's data and end-of-packet flag.
    always_comb begin
        data_sel = '0;
        last_sel = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                data_sel = bus.in_data[i*W +: W];
`ifdef STREAM_MUX_LAST_EN
                last_sel = bus.in_last[i];
`endif
            end
        end
    end

`ifndef STREAM_MUX_LAST_EN
    // in_last has no effect in per-beat mode.
    logic unused_in_last;
    assign unused_in_last = ^bus.in_last;
`endif

    assign bus.in_ready  = load ? grant : '0;

    assign bus.out_data  = data_p1;
    assign bus.out_last  = last_p1;
    assign bus.out_sel   = sel_p1;
    assign bus.out_valid = vld_p1;

    // ---- stage p1: output register, pointer and lock update ----
    // Load a granted beat, drain to empty when nothing is granted, hold when stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1 <= '0;
            last_p1 <= 1'b0;
            sel_p1  <= '0;
            vld_p1  <= 1'b0;
            ptr     <= '0;
`ifdef STREAM_MUX_LAST_EN
            lock    <= 1'b0;
            lock_ch <= '0;
`endif
        end else if (load) begin
            if (xfer) begin
                data_p1 <= data_sel;
                sel_p1  <= gidx;
                vld_p1  <= 1'b1;
`ifdef STREAM_MUX_LAST_EN
                last_p1 <= last_sel;
                if (last_sel) begin
                    lock <= 1'b0;
                    ptr  <= next_ptr(gidx);
                end else begin
                    lock    <= 1'b1;
                    lock_ch <= gidx;
                end
`else
                last_p1 <= 1'b0;
                ptr     <= next_ptr(gidx);
`endif
            end else begin
                vld_p1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr (N=4, W=8).
// Packet-mode scenarios are compiled in only when STREAM_MUX_LAST_EN is defined.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    stream_mux_rr_if #(.N(4), .W(8)) bus ();

    stream_mux_rr #(.N(4), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 4'b0000;
        bus.in_last  = 4'b0000;
        bus.in_data  = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if (bus.in_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_in_ready cycle %0d: got %b want 0000", c, bus.in_ready);
            end
            tick();
            vectors++;
            if (bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out_valid cycle %0d: got %b want 0", c, bus.out_valid);
            end
            vectors++;
            if (bus.out_data !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_out_data cycle %0d: got %h want 00", c, bus.out_data);
            end
            vectors++;
            if (bus.out_sel !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_out_sel cycle %0d: got %0d want 0", c, bus.out_sel);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [7:0] exp_data;
        bus.out_ready = 1'b1;
        bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.in_valid  = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_rdy  = 4'b0001 << (k % 4);
            exp_data = 8'hA0 + 8'(k % 4);
            #1;
            vectors++;
            if (bus.in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rr_in_ready beat %0d: got %b want %b", k, bus.in_ready, exp_rdy);
            end
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(k % 4) || bus.out_data !== exp_data) begin
                miscompares++;
                $display("FAIL rr_out beat %0d: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         k, bus.out_valid, bus.out_sel, bus.out_data, k % 4, exp_data);
            end
        end
        idle_inputs();
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_drain: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_stall();
        // ptr is 0 here; only channel 2 valid.
        bus.in_data   = {8'h00, 8'h5C, 8'h00, 8'h00};
        bus.in_valid  = 4'b0100;
        bus.out_ready = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL stall_first_ready: got %b want 0100", bus.in_ready);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5C || bus.out_sel !== 2'd2) begin
                miscompares++;
                $display("FAIL stall_hold cycle %0d: got v=%b data=%h sel=%0d want v=1 data=5c sel=2",
                         c, bus.out_valid, bus.out_data, bus.out_sel);
            end
            vectors++;
            if (bus.in_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall_in_ready cycle %0d: got %b want 0000", c, bus.in_ready);
            end
            if (c < 2) tick();
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL stall_release_ready: got %b want 0100", bus.in_ready);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5C || bus.out_sel !== 2'd2) begin
            miscompares++;
            $display("FAIL stall_second_beat: got v=%b data=%h sel=%0d want v=1 data=5c sel=2",
                     bus.out_valid, bus.out_data, bus.out_sel);
        end
        idle_inputs();
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_drain: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_wrap();
        // Serve channel 3 so ptr wraps to 0.
        bus.out_ready = 1'b1;
        bus.in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
        bus.in_valid  = 4'b1000;
        tick();
        vectors++;
        if (bus.out_sel !== 2'd3 || bus.out_data !== 8'h33) begin
            miscompares++;
            $display("FAIL wrap_ch3: got sel=%0d data=%h want sel=3 data=33", bus.out_sel, bus.out_data);
        end
        bus.in_valid = 4'b1010;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL wrap_ready_ch1: got %b want 0010", bus.in_ready);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1 || bus.out_data !== 8'h11) begin
            miscompares++;
            $display("FAIL wrap_out_ch1: got v=%b sel=%0d data=%h want v=1 sel=1 data=11",
                     bus.out_valid, bus.out_sel, bus.out_data);
        end
        #1;
        vectors++;
        if (bus.in_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL wrap_ready_ch3: got %b want 1000", bus.in_ready);
        end
        tick();
        vectors++;
        if (bus.out_sel !== 2'd3 || bus.out_data !== 8'h33 || bus.out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_out_ch3: got sel=%0d data=%h last=%b want sel=3 data=33 last=0",
                     bus.out_sel, bus.out_data, bus.out_last);
        end
        idle_inputs();
        tick();
    endtask

`ifdef STREAM_MUX_LAST_EN
    task automatic test_packet();
        logic [7:0] d0 [3] = '{8'hD0, 8'hD1, 8'hD2};
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) begin
                // Channel 0 pauses mid-packet for two cycles.
                for (int g = 0; g < 2; g++) begin
                    bus.in_valid = 4'b0010;
                    bus.in_data  = {8'h00, 8'h00, 8'h10, 8'h00};
                    bus.in_last  = 4'b0010;
                    #1;
                    vectors++;
                    if (bus.in_ready !== 4'b0000) begin
                        miscompares++;
                        $display("FAIL pkt_gap_ready %0d: got %b want 0000", g, bus.in_ready);
                    end
                    tick();
                    vectors++;
                    if (bus.out_valid !== 1'b0) begin
                        miscompares++;
                        $display("FAIL pkt_gap_idle %0d: got out_valid=%b want 0", g, bus.out_valid);
                    end
                end
            end
            bus.in_valid = 4'b0011;
            bus.in_data  = {8'h00, 8'h00, 8'h10, d0[b]};
            bus.in_last  = (b == 2) ? 4'b0011 : 4'b0010;
            #1;
            vectors++;
            if (bus.in_ready !== 4'b0001) begin
                miscompares++;
                $display("FAIL pkt_ready beat %0d: got %b want 0001", b, bus.in_ready);
            end
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd0 || bus.out_data !== d0[b] ||
                bus.out_last !== (b == 2)) begin
                miscompares++;
                $display("FAIL pkt_out beat %0d: got v=%b sel=%0d data=%h last=%b want v=1 sel=0 data=%h last=%b",
                         b, bus.out_valid, bus.out_sel, bus.out_data, bus.out_last, d0[b], b == 2);
            end
        end
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL pkt_next_ready: got %b want 0010", bus.in_ready);
        end
        tick();
        vectors++;
        if (bus.out_sel !== 2'd1 || bus.out_data !== 8'h10 || bus.out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL pkt_next_out: got sel=%0d data=%h last=%b want sel=1 data=10 last=1",
                     bus.out_sel, bus.out_data, bus.out_last);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_packet();
        // ptr is 2: channel 2 starts a packet and the beat is held.
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0100;
        bus.in_data   = {8'h00, 8'h22, 8'h00, 8'h0F};
        bus.in_last   = 4'b0000;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2) begin
            miscompares++;
            $display("FAIL rstpkt_held: got v=%b sel=%0d want v=1 sel=2", bus.out_valid, bus.out_sel);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            miscompares++;
            $display("FAIL rstpkt_cleared: got v=%b data=%h want v=0 data=00", bus.out_valid, bus.out_data);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0101;
        bus.in_last   = 4'b0101;
        #1;
        vectors++;
        if (bus.in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL rstpkt_ready: got %b want 0001", bus.in_ready);
        end
        tick();
        vectors++;
        if (bus.out_sel !== 2'd0 || bus.out_data !== 8'h0F) begin
            miscompares++;
            $display("FAIL rstpkt_out: got sel=%0d data=%h want sel=0 data=0f", bus.out_sel, bus.out_data);
        end
        idle_inputs();
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_stall();
        test_wrap();
`ifdef STREAM_MUX_LAST_EN
        test_packet();
        test_reset_mid_packet();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
